// File: rtl/seconds_display_pkg.sv
// Shared types and constants for the seconds BCD display block.
package seconds_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // All segments off on an active-low display.
  localparam logic [6:0] BLANK = 7'h7F;

  // Active-low segment patterns, bit order g..a, for digits 0-9.
  localparam logic [6:0] SEG7 [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seconds_bcd_display_if.sv
// Bus between the upstream counter/controls and the seconds display block.
interface seconds_bcd_display_if #(
  parameter int CNT_W = 26
);

  logic             En;
  logic             Pause;
  logic [CNT_W-1:0] Count;
  logic             CntClr;
  logic             Tick;
  logic             Wrap;
  logic [3:0]       Digit0;
  logic [3:0]       Digit1;
  logic [6:0]       Hex0;
  logic [6:0]       Hex1;

  // Controls and counter value side.
  modport master (
    output En, Pause, Count,
    input  CntClr, Tick, Wrap, Digit0, Digit1, Hex0, Hex1
  );

  // Display block side.
  modport slave (
    input  En, Pause, Count,
    output CntClr, Tick, Wrap, Digit0, Digit1, Hex0, Hex1
  );

endinterface

// File: rtl/seconds_bcd_display_seg7_decoder.sv
// One BCD digit to an active-low 7-segment pattern; non-BCD codes blank.
module seg7_decoder
  import seconds_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup for 0-9, blank for anything else.
  always_comb begin
    seg = BLANK;
    if (digit <= 4'd9) seg = SEG7[digit];
  end

endmodule

// File: rtl/seconds_bcd_display.sv
// Terminal-count detector, tick/clear generator, two-digit BCD seconds
// counter and dual 7-segment drive for the DE2 HEX0/HEX1 displays.
module seconds_bcd_display
  import seconds_display_pkg::*;
#(
  parameter int CNT_W    = 26,
  parameter int TERMINAL = 49_999_998,
  parameter int MODULO   = 60
) (
  input  logic                  Clk,
  input  logic                  Clr,
  seconds_bcd_display_if.slave  bus
);

  localparam logic [CNT_W-1:0] TERM_CNT   = CNT_W'(TERMINAL);
  localparam logic [3:0]       LAST_TENS  = 4'((MODULO - 1) / 10);
  localparam logic [3:0]       LAST_UNITS = 4'((MODULO - 1) % 10);

  state_e     state_q, state_d;
  logic       tick_q, tick_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       wrap_q, wrap_d;
  logic [3:0] digit0_q, digit0_d;
  logic [3:0] digit1_q, digit1_d;
  logic       hit;
  logic [6:0] seg0, seg1;

  // State, tick/clear strobes and BCD digits.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= IDLE;
      tick_q    <= 1'b0;
      cnt_clr_q <= 1'b1;
      wrap_q    <= 1'b0;
      digit0_q  <= 4'd0;
      digit1_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      cnt_clr_q <= cnt_clr_d;
      wrap_q    <= wrap_d;
      digit0_q  <= digit0_d;
      digit1_q  <= digit1_d;
    end
  end

  // Next-state, terminal-count hit and BCD increment.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    digit0_d = digit0_q;
    digit1_d = digit1_q;

    // The cnt_clr_q mask suppresses a second hit while the counter clears.
    hit = (state_q == RUN) && bus.En && (bus.Count == TERM_CNT) && !cnt_clr_q;

    unique case (state_q)
      IDLE:    if (bus.En && !bus.Pause) state_d = RUN;
      RUN:     if (bus.Pause)            state_d = HOLD;
      HOLD:    if (!bus.Pause)           state_d = RUN;
      default:                           state_d = IDLE;
    endcase

    // Hold the counter cleared whenever either side of the edge is not RUN,
    // so it restarts from zero and stays cleared from the first HOLD cycle.
    cnt_clr_d = hit || (state_q != RUN) || (state_d != RUN);
    tick_d    = hit;

    if (hit) begin
      if (digit1_q == LAST_TENS && digit0_q == LAST_UNITS) begin
        digit0_d = 4'd0;
        digit1_d = 4'd0;
        wrap_d   = 1'b1;
      end else if (digit0_q == 4'd9) begin
        digit0_d = 4'd0;
        digit1_d = digit1_q + 4'd1;
      end else begin
        digit0_d = digit0_q + 4'd1;
      end
    end
  end

  seg7_decoder u_seg0 (.digit(digit0_q), .seg(seg0));
  seg7_decoder u_seg1 (.digit(digit1_q), .seg(seg1));

  assign bus.CntClr = cnt_clr_q;
  assign bus.Tick   = tick_q;
  assign bus.Wrap   = wrap_q;
  assign bus.Digit0 = digit0_q;
  assign bus.Digit1 = digit1_q;
  assign bus.Hex0   = (state_q == IDLE) ? BLANK : seg0;
  assign bus.Hex1   = (state_q == IDLE) ? BLANK : seg1;

endmodule

// File: tb/tb_seconds_bcd_display.sv
// Directed bench for seconds_bcd_display with a behavioural 26-bit counter
// (async clear from CntClr, count enable from En) closing the loop.
module tb_seconds_bcd_display;

  localparam int CNT_W    = 26;
  localparam int TERMINAL = 3;
  localparam int MODULO   = 12;

  logic clk;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  logic stray_wrap;

  seconds_bcd_display_if #(.CNT_W(CNT_W)) bus ();

  seconds_bcd_display #(
    .CNT_W(CNT_W), .TERMINAL(TERMINAL), .MODULO(MODULO)
  ) dut (
    .Clk(clk),
    .Clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream counter: asynchronous clear, counts while enabled.
  always @(posedge clk or posedge bus.CntClr) begin
    if (bus.CntClr) bus.Count <= '0;
    else if (bus.En) bus.Count <= bus.Count + 26'd1;
  end

  typedef struct {
    int         gap;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       wrap;
  } tick_vec_t;

  tick_vec_t  vecs [17];
  logic [6:0] seg_ref [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for Tick at negedges; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.Wrap && !bus.Tick) stray_wrap = 1'b1;
    end while (!bus.Tick && n < 20);
  endtask

  task automatic check_digits(input string tag, input logic [3:0] d1, input logic [3:0] d0);
    check({tag, "_digits"}, {bus.Digit1, bus.Digit0}, {d1, d0});
    check({tag, "_hex0"}, bus.Hex0, seg_ref[d0]);
    check({tag, "_hex1"}, bus.Hex1, seg_ref[d1]);
  endtask

  task automatic expect_tick(input string tag, input int gap, input logic [3:0] d1,
                             input logic [3:0] d0, input logic wrap);
    int n;
    wait_tick(n);
    check({tag, "_gap"}, n, gap);
    check_digits(tag, d1, d0);
    check({tag, "_wrap"}, bus.Wrap, wrap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;

    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0]  = '{6, 4'd0, 4'd1, 1'b0};
    vecs[1]  = '{5, 4'd0, 4'd2, 1'b0};
    vecs[2]  = '{5, 4'd0, 4'd3, 1'b0};
    vecs[3]  = '{5, 4'd0, 4'd4, 1'b0};
    vecs[4]  = '{5, 4'd0, 4'd5, 1'b0};
    vecs[5]  = '{5, 4'd0, 4'd6, 1'b0};
    vecs[6]  = '{5, 4'd0, 4'd7, 1'b0};
    vecs[7]  = '{5, 4'd0, 4'd8, 1'b0};
    vecs[8]  = '{5, 4'd0, 4'd9, 1'b0};
    vecs[9]  = '{5, 4'd1, 4'd0, 1'b0};
    vecs[10] = '{5, 4'd1, 4'd1, 1'b0};
    vecs[11] = '{5, 4'd0, 4'd0, 1'b1};
    vecs[12] = '{5, 4'd0, 4'd1, 1'b0};
    vecs[13] = '{5, 4'd0, 4'd2, 1'b0};
    vecs[14] = '{5, 4'd0, 4'd3, 1'b0};
    vecs[15] = '{5, 4'd0, 4'd4, 1'b0};
    vecs[16] = '{5, 4'd0, 4'd5, 1'b0};

    clr        = 1'b0;
    bus.En     = 1'b0;
    bus.Pause  = 1'b0;
    stray_wrap = 1'b0;

    // Reset values, before any clock edge.
    #1 clr = 1'b1;
    #1;
    check("rst_cntclr", bus.CntClr, 1'b1);
    check("rst_tick", bus.Tick, 1'b0);
    check("rst_wrap", bus.Wrap, 1'b0);
    check("rst_digits", {bus.Digit1, bus.Digit0}, 8'h00);
    check("rst_hex", {bus.Hex1, bus.Hex0}, {7'h7F, 7'h7F});

    repeat (2) @(negedge clk);
    clr = 1'b0;

    // IDLE holds with En=0 and with Pause=1.
    repeat (3) @(negedge clk);
    check("idle_hex", {bus.Hex1, bus.Hex0}, {7'h7F, 7'h7F});
    check("idle_cntclr", bus.CntClr, 1'b1);
    bus.En    = 1'b1;
    bus.Pause = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pause_hex", {bus.Hex1, bus.Hex0}, {7'h7F, 7'h7F});
    check("idle_pause_count", bus.Count, 0);

    // Leave IDLE, count a full wrap and on to 05.
    bus.Pause = 1'b0;
    for (int i = 0; i < 17; i++)
      expect_tick($sformatf("run%0d", i), vecs[i].gap, vecs[i].d1, vecs[i].d0, vecs[i].wrap);

    // Pause at 05 for 20 cycles.
    bus.Pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d", i), {bus.Tick, bus.CntClr, bus.Digit1, bus.Digit0, bus.Count[3:0]},
            {1'b0, 1'b1, 4'd0, 4'd5, 4'd0});
    end
    check_digits("hold_end", 4'd0, 4'd5);
    bus.Pause = 1'b0;
    expect_tick("unpause", 6, 4'd0, 4'd6, 1'b0);

    // En low at Count=2 freezes everything; CntClr stays low.
    repeat (3) @(negedge clk);
    check("en_off_count", bus.Count, 2);
    bus.En = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("en_off%0d", i), {bus.Tick, bus.CntClr, bus.Digit1, bus.Digit0, bus.Count[3:0]},
            {1'b0, 1'b0, 4'd0, 4'd6, 4'd2});
    end
    bus.En = 1'b1;
    expect_tick("en_on", 2, 4'd0, 4'd7, 1'b0);

    // Run on to 03 using a decimal reference count.
    m = 7;
    for (int i = 0; i < 8; i++) begin
      m = (m + 1) % MODULO;
      expect_tick($sformatf("cycle%0d", i), 5, 4'(m / 10), 4'(m % 10), m == 0);
    end

    // Pause rises during the hit cycle: the tick still counts.
    repeat (4) @(negedge clk);
    check("hit_cycle_count", bus.Count, TERMINAL);
    bus.Pause = 1'b1;
    @(negedge clk);
    check("pause_hit_tick", bus.Tick, 1'b1);
    check_digits("pause_hit", 4'd0, 4'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("pause_hold%0d", i), {bus.Tick, bus.CntClr, bus.Digit1, bus.Digit0},
            {1'b0, 1'b1, 4'd0, 4'd4});
    end

    // Asynchronous Clr in the middle of a running period.
    bus.Pause = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_cntclr", bus.CntClr, 1'b1);
    check("clr_tick", bus.Tick, 1'b0);
    check("clr_wrap", bus.Wrap, 1'b0);
    check("clr_digits", {bus.Digit1, bus.Digit0}, 8'h00);
    check("clr_hex", {bus.Hex1, bus.Hex0}, {7'h7F, 7'h7F});
    check("clr_count", bus.Count, 0);
    @(negedge clk);
    bus.En = 1'b0;
    clr    = 1'b0;
    repeat (3) @(negedge clk);
    check("post_clr_idle", {bus.CntClr, bus.Hex1, bus.Hex0}, {1'b1, 7'h7F, 7'h7F});

    check("no_stray_wrap", stray_wrap, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
